// File: rtl/cpu_bus_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_if -- memory/IO bus interface sitting directly behind the 65C02 core.
//
// Each core access is decoded into one of three regions (RAM, ROM, IO page).
// The block returns read data (cpu_di) and a combinational ready (cpu_rdy) to
// the core. It adds per-region wait states, and it runs a req/ack handshake
// towards slow IO peripherals.
//
// Optional feature: define BUS_TIMEOUT_EN to bound the IO handshake to
// TIMEOUT cycles. An expired handshake returns 8'hFF and sets the sticky
// bus_err flag. Without the macro, the handshake waits indefinitely and
// bus_err is tied low.
// ---------------------------------------------------------------------------
module cpu_bus_if #(
    parameter logic [7:0] IO_PAGE  = 8'hFE,
    parameter logic [3:0] ROM_HI   = 4'hF,
    parameter int         ROM_WAIT = 1,
    parameter int         RAM_WAIT = 0,
    parameter int         TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        RST,
    // core side
    input  logic [15:0] cpu_ad,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    // RAM side
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    // ROM side
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_rdata,
    // IO side
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_we,
    output logic        io_req,
    input  logic        io_ack,
    input  logic [7:0]  io_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_ROM = 2'd1,
        REG_IO  = 2'd2
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_IO_REQ  = 2'd2,
        ST_IO_DONE = 2'd3
    } state_t;

    localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_W = 4'(RAM_WAIT);

    region_t    region;
    region_t    rd_sel;
    logic [3:0] region_wait;
    state_t     state;
    state_t     next_state;
    logic [3:0] wcnt;
    logic [7:0] io_dreg;
    logic       io_timeout;

    // Memory ports are straight pass-throughs of the core bus.
    assign ram_addr  = cpu_ad;
    assign ram_wdata = cpu_do;
    assign rom_addr  = cpu_ad[11:0];

    // Address decode: the IO page wins over ROM, and everything else is RAM.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
        region      = REG_RAM;
        region_wait = RAM_W;
        if (cpu_ad[15:8] == IO_PAGE) begin
            region      = REG_IO;
            region_wait = 4'd0;
        end else if (cpu_ad[15:12] == ROM_HI) begin
            region      = REG_ROM;
            region_wait = ROM_W;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge RST) begin
        // NOTE: sequential state uses non-blocking (<=), so every register samples pre-edge values regardless of block order.
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (region == REG_IO) begin
                    next_state = ST_IO_REQ;
                end else if (region_wait != 4'd0) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt == 4'd0) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IO_REQ: begin
                if (io_ack || io_timeout) begin
                    next_state = ST_IO_DONE;
                end
            end
            ST_IO_DONE: begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output logic: the core is released on the cycle whose edge completes the access.
    always_comb begin
        cpu_rdy = 1'b0;
        unique case (state)
            ST_IDLE:    cpu_rdy = (region != REG_IO) && (region_wait == 4'd0);
            ST_WAIT:    cpu_rdy = (wcnt == 4'd0);
            ST_IO_REQ:  cpu_rdy = 1'b0;
            ST_IO_DONE: cpu_rdy = 1'b1;
            default:    cpu_rdy = 1'b0;
        endcase
    end

    // A RAM write commits only on the accepting edge, never during wait states.
    assign ram_we = cpu_we && cpu_rdy && (region == REG_RAM);

    // Wait-state counter: loaded with W-1 on leaving IDLE, then counted down to zero.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wcnt <= 4'd0;
        end else if (state == ST_IDLE) begin
            if (next_state == ST_WAIT) begin
                wcnt <= region_wait - 4'd1;
            end
        end else if (state == ST_WAIT) begin
            if (wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    // IO request fields are captured once when the IO access is first seen.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            io_addr  <= 8'h00;
            io_wdata <= 8'h00;
            io_we    <= 1'b0;
        end else if ((state == ST_IDLE) && (region == REG_IO)) begin
            io_addr  <= cpu_ad[7:0];
            io_wdata <= cpu_do;
            io_we    <= cpu_we;
        end
    end

    // io_req is registered, so the peripheral sees a glitch-free request.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            io_req <= 1'b0;
        end else begin
            io_req <= (next_state == ST_IO_REQ);
        end
    end

    // IO read data holding register: filled on the ack of a read, forced to FF on a timeout.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            io_dreg <= 8'hFF;
        end else if (state == ST_IO_REQ) begin
            if (io_ack) begin
                if (!io_we) begin
                    io_dreg <= io_rdata;
                end
            end else if (io_timeout) begin
                io_dreg <= 8'hFF;
            end
        end
    end

    // Read-data source follows the region accepted at the last ready edge.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rd_sel <= REG_IO;
        end else if (cpu_rdy) begin
            rd_sel <= region;
        end
    end

    // Read-data mux towards the core.
    always_comb begin
        cpu_di = io_dreg;
        unique case (rd_sel)
            REG_RAM: cpu_di = ram_rdata;
            REG_ROM: cpu_di = rom_rdata;
            default: cpu_di = io_dreg;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tcnt;

    // An ack arriving on the expiry cycle takes priority over the timeout.
    assign io_timeout = (state == ST_IO_REQ) && (tcnt == '0) && !io_ack;

    // Handshake timeout counter: loaded on entry to IO_REQ, counts down while waiting.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            tcnt <= '0;
        end else if ((state == ST_IDLE) && (next_state == ST_IO_REQ)) begin
            tcnt <= TW'(TIMEOUT - 1);
        end else if ((state == ST_IO_REQ) && (tcnt != '0)) begin
            tcnt <= tcnt - TW'(1);
        end
    end

    // Sticky bus error: only reset clears it.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            bus_err <= 1'b0;
        end else if (io_timeout) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign io_timeout = 1'b0;
    assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_if.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_if -- self-checking bench for cpu_bus_if.
// The main instance uses ROM_WAIT=2, RAM_WAIT=0 and TIMEOUT=4.
// A second instance with RAM_WAIT=1 covers RAM writes that take wait states.
// The expected behaviour comes from an access-level model. For each access,
// the model derives the ready cycle, the strobes and the returned data from
// the region rules. Memory contents come from a byte array.
// ---------------------------------------------------------------------------
module tb_cpu_bus_if;

    localparam int ROM_W = 2;
    localparam int RAM_W = 0;
    localparam int TOUT  = 4;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] cpu_ad;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [11:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic        io_we;
    logic        io_req;
    logic        io_ack;
    logic [7:0]  io_rdata;
    logic        bus_err;

    // second instance (RAM_WAIT=1)
    logic [15:0] w_ad;
    logic [7:0]  w_do;
    logic        w_we;
    logic [7:0]  w_di;
    logic        w_rdy;
    logic [15:0] w_ram_addr;
    logic        w_ram_we;
    logic [7:0]  w_ram_wdata;
    logic [7:0]  w_ram_rdata;
    logic [11:0] w_rom_addr;
    logic [7:0]  w_rom_rdata;
    logic [7:0]  w_io_addr;
    logic [7:0]  w_io_wdata;
    logic        w_io_we;
    logic        w_io_req;
    logic        w_io_ack;
    logic [7:0]  w_io_rdata;
    logic        w_bus_err;

    int n_cmp;
    int n_fail;

    // reference model state
    logic [7:0] emem [0:65535];
    logic [7:0] last_io;
    logic       exp_err;
    logic       pend_valid;
    logic [7:0] pend_di;

    // peripheral RAM storage
    logic [7:0] pmem [0:65535];
    bit         pwr  [0:65535];

    cpu_bus_if #(
        .IO_PAGE(8'hFE), .ROM_HI(4'hF), .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .RST(RST),
        .cpu_ad(cpu_ad), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_req(io_req),
        .io_ack(io_ack), .io_rdata(io_rdata), .bus_err(bus_err)
    );

    cpu_bus_if #(
        .IO_PAGE(8'hFE), .ROM_HI(4'hF), .ROM_WAIT(1), .RAM_WAIT(1), .TIMEOUT(TOUT)
    ) dut_w (
        .clk(clk), .RST(RST),
        .cpu_ad(w_ad), .cpu_do(w_do), .cpu_we(w_we), .cpu_di(w_di), .cpu_rdy(w_rdy),
        .ram_addr(w_ram_addr), .ram_we(w_ram_we), .ram_wdata(w_ram_wdata), .ram_rdata(w_ram_rdata),
        .rom_addr(w_rom_addr), .rom_rdata(w_rom_rdata),
        .io_addr(w_io_addr), .io_wdata(w_io_wdata), .io_we(w_io_we), .io_req(w_io_req),
        .io_ack(w_io_ack), .io_rdata(w_io_rdata), .bus_err(w_bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h58;
    endfunction

    function automatic logic [7:0] rom_fn(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h96;
    endfunction

    // synchronous RAM peripheral, read-before-write, 1-cycle latency
    always @(posedge clk) begin
        ram_rdata <= pwr[ram_addr] ? pmem[ram_addr] : init_fn(ram_addr);
        if (ram_we) begin
            pmem[ram_addr] <= ram_wdata;
            pwr[ram_addr]  <= 1'b1;
        end
    end

    // synchronous ROM peripheral, 1-cycle latency
    always @(posedge clk) begin
        rom_rdata <= rom_fn(rom_addr);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One core access. Entered just after a clock edge, with the DUT ready for
    // a new address. Returns just after the accepting edge.
    // k: cycle of io_req on which the peripheral acks (0 = never acks).
    // rdv: IO read value, or -1 to pick one at random.
    task automatic do_access(input logic [15:0] a, input logic w, input logic [7:0] d,
                             input int k, input int rdv);
        int         reg_k;
        int         nreq;
        int         acc;
        int         seen;
        logic [7:0] ack_data;
        if (a[15:8] == 8'hFE)       reg_k = 2;
        else if (a[15:12] == 4'hF)  reg_k = 1;
        else                        reg_k = 0;
        nreq = (reg_k == 2) ? ((k == 0) ? TOUT : k) : 0;
        acc  = (reg_k == 0) ? RAM_W : (reg_k == 1) ? ROM_W : 1 + nreq;
        if (reg_k == 2 && k == 0) exp_err = 1'b1;
        cpu_ad   = a;
        cpu_do   = d;
        cpu_we   = w;
        seen     = 0;
        ack_data = 8'hFF;
        for (int c = 0; c <= acc; c++) begin
            @(negedge clk);
            if (c == 0 && pend_valid) check("cpu_di", 16'(cpu_di), 16'(pend_di));
            check("cpu_rdy", 16'(cpu_rdy), 16'(c == acc));
            check("ram_we", 16'(ram_we), 16'(c == acc && reg_k == 0 && w));
            check("io_req", 16'(io_req), 16'(reg_k == 2 && c >= 1 && c <= nreq));
            if (c == 0) check("ram_addr", ram_addr, a);
            if (reg_k == 1) check("rom_addr", 16'(rom_addr), 16'(a[11:0]));
            if (reg_k == 2 && c == 1) begin
                check("io_addr", 16'(io_addr), 16'(a[7:0]));
                check("io_wdata", 16'(io_wdata), 16'(d));
                check("io_we", 16'(io_we), 16'(w));
            end
            if (c == acc) check("bus_err", 16'(bus_err), 16'(exp_err));
            // IO peripheral: ack on the k-th request cycle, noise while idle
            io_rdata = (rdv >= 0) ? 8'(rdv) : 8'($urandom);
            if (io_req === 1'b1) begin
                seen++;
                io_ack = (seen == k);
                if (io_ack) ack_data = io_rdata;
            end else begin
                io_ack = 1'($urandom_range(0, 1));
            end
            if (c < acc) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        io_ack = 1'b0;
        // model update
        case (reg_k)
            0: begin
                pend_di = emem[a];
                if (w) emem[a] = d;
            end
            1: pend_di = rom_fn(a[11:0]);
            default: begin
                if (k == 0)   last_io = 8'hFF;
                else if (!w)  last_io = ack_data;
                pend_di = last_io;
            end
        endcase
        pend_valid = 1'b1;
    endtask

    initial begin
        logic [15:0] ra;
        logic [11:0] lo;
        int          r;
        int          kk;
        int          ok;

        n_cmp      = 0;
        n_fail     = 0;
        last_io    = 8'hFF;
        exp_err    = 1'b0;
        pend_valid = 1'b0;
        pend_di    = 8'hFF;
        for (int i = 0; i < 65536; i++) emem[i] = init_fn(16'(i));

        RST         = 1'b0;
        cpu_ad      = 16'h0200;
        cpu_do      = 8'h00;
        cpu_we      = 1'b0;
        io_ack      = 1'b0;
        io_rdata    = 8'h00;
        w_ad        = 16'h0100;
        w_do        = 8'h00;
        w_we        = 1'b0;
        w_ram_rdata = 8'h00;
        w_rom_rdata = 8'h00;
        w_io_ack    = 1'b0;
        w_io_rdata  = 8'h00;

        // reset state
        #12;
        check("rst_cpu_di", 16'(cpu_di), 16'h00FF);
        check("rst_cpu_rdy", 16'(cpu_rdy), 16'd1);
        check("rst_io_req", 16'(io_req), 16'd0);
        check("rst_io_we", 16'(io_we), 16'd0);
        check("rst_io_addr", 16'(io_addr), 16'd0);
        check("rst_io_wdata", 16'(io_wdata), 16'd0);
        check("rst_bus_err", 16'(bus_err), 16'd0);
        check("rst_ram_we", 16'(ram_we), 16'd0);
        @(posedge clk);
        #1;
        RST = 1'b1;
        #1;
        check("rel_cpu_di", 16'(cpu_di), 16'h00FF);
        pend_valid = 1'b1;
        pend_di    = 8'hFF;

        // directed accesses
        do_access(16'h0200, 1'b0, 8'h00, 0, -1);   // RAM read, 5A expected next
        do_access(16'hF123, 1'b0, 8'h00, 0, -1);   // ROM read, 2 waits
        do_access(16'hFE07, 1'b0, 8'h00, 3, 8'h3C); // IO read, ack on 3rd cycle
        do_access(16'h0010, 1'b1, 8'hA5, 0, -1);   // RAM write
        do_access(16'h0010, 1'b0, 8'h00, 0, -1);   // RAM read back
        do_access(16'hFDFF, 1'b0, 8'h00, 0, -1);   // ROM just below the IO page
        do_access(16'hEFFF, 1'b0, 8'h00, 0, -1);   // RAM just below ROM
        do_access(16'hFF80, 1'b1, 8'h5A, 0, -1);   // ROM write: no strobe
        do_access(16'hFE10, 1'b1, 8'hC3, 1, -1);   // IO write, ack at once
        do_access(16'hFE11, 1'b0, 8'h00, 1, 8'h96); // IO read, ack at once
        do_access(16'h0010, 1'b0, 8'h00, 0, -1);
        do_access(16'h0300, 1'b0, 8'h00, 0, -1);   // main idles on this read

        // RAM write with one wait state on the second instance
        ok = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (w_rdy === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check("w_align", 16'(ok), 16'd1);
        check("w_di", 16'(w_di), 16'h0000);
        @(posedge clk);
        #1;
        w_ad = 16'h0010;
        w_do = 8'hA5;
        w_we = 1'b1;
        @(negedge clk);
        check("w_rdy_c0", 16'(w_rdy), 16'd0);
        check("w_ram_we_c0", 16'(w_ram_we), 16'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("w_rdy_c1", 16'(w_rdy), 16'd1);
        check("w_ram_we_c1", 16'(w_ram_we), 16'd1);
        check("w_ram_addr", w_ram_addr, 16'h0010);
        check("w_ram_wdata", 16'(w_ram_wdata), 16'h00A5);
        check("w_rom_addr", 16'(w_rom_addr), 16'h0010);
        @(posedge clk);
        #1;
        w_we = 1'b0;
        w_ad = 16'h0020;
        @(negedge clk);
        check("w_ram_we_c2", 16'(w_ram_we), 16'd0);
        check("w_rdy_c2", 16'(w_rdy), 16'd0);
        check("w_io_req", 16'(w_io_req), 16'd0);
        check("w_io_fields", {w_io_addr, w_io_wdata}, 16'h0000);
        check("w_io_we", 16'(w_io_we), 16'd0);
        check("w_bus_err", 16'(w_bus_err), 16'd0);
        @(posedge clk);
        #1;

`ifdef BUS_TIMEOUT_EN
        do_access(16'hFE20, 1'b0, 8'h00, 0, -1);     // no ack: timeout, FF, bus_err
        do_access(16'h0400, 1'b0, 8'h00, 0, -1);     // bus_err stays set
        do_access(16'hFE21, 1'b0, 8'h00, TOUT, 8'h11); // ack on the expiry cycle wins
        do_access(16'hFE22, 1'b1, 8'h77, 0, -1);     // write timeout
        do_access(16'hF010, 1'b0, 8'h00, 0, -1);
`endif

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 2);
            case (r)
                0: ra = {4'($urandom_range(0, 14)), 8'h00, 4'($urandom)};
                1: begin
                    lo = 12'($urandom);
                    if (lo[11:8] == 4'hE) lo[11:8] = 4'hD;
                    ra = {4'hF, lo};
                end
                default: ra = {8'hFE, 8'($urandom)};
            endcase
`ifdef BUS_TIMEOUT_EN
            kk = $urandom_range(0, TOUT);
`else
            kk = $urandom_range(1, 6);
`endif
            do_access(ra, 1'($urandom_range(0, 1)), 8'($urandom), kk, -1);
        end

        // asynchronous reset in the middle of an IO handshake
        io_ack = 1'b0;
        cpu_ad = 16'hFE33;
        cpu_we = 1'b0;
        @(negedge clk);
        check("mid_req_before", 16'(io_req), 16'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_req_active", 16'(io_req), 16'd1);
        #1;
        RST = 1'b0;
        #1;
        check("mid_io_req", 16'(io_req), 16'd0);
        check("mid_cpu_di", 16'(cpu_di), 16'h00FF);
        check("mid_cpu_rdy_io", 16'(cpu_rdy), 16'd0);
        check("mid_io_addr", 16'(io_addr), 16'd0);
        check("mid_bus_err", 16'(bus_err), 16'd0);
        cpu_ad = 16'h0300;
        #1;
        check("mid_cpu_rdy_ram", 16'(cpu_rdy), 16'd1);
        @(posedge clk);
        #1;
        RST        = 1'b1;
        last_io    = 8'hFF;
        exp_err    = 1'b0;
        pend_valid = 1'b1;
        pend_di    = 8'hFF;
        do_access(16'h0300, 1'b0, 8'h00, 0, -1);
        do_access(16'hFE07, 1'b0, 8'h00, 2, 8'h44);
        do_access(16'h0010, 1'b0, 8'h00, 0, -1);
        do_access(16'hF456, 1'b0, 8'h00, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_if.md
Name: cpu_bus_if

Overview:
Memory/IO bus interface directly downstream of the 65C02 core. It consumes the core's combinational address, data-out and write-enable, and decodes each access into one of three regions: RAM, ROM or an IO page. It produces the core's DI and RDY inputs, adding per-region wait states and a req/ack handshake towards slow IO peripherals.

Parameters:
IO_PAGE, 8'hFE, AD[15:8] value selecting the IO page (256 bytes).
ROM_HI, 4'hF, AD[15:12] value selecting ROM; the IO page takes precedence.
ROM_WAIT, 1, wait states inserted on ROM reads (0..15).
RAM_WAIT, 0, wait states inserted on RAM accesses (0..15).
TIMEOUT, 16, IO handshake timeout in cycles (only with the optional feature).

Ports:
clk  in  1  CPU clock
RST  in  1  asynchronous, active-low reset
cpu_ad  in  16  core address bus; held stable by the core while cpu_rdy=0
cpu_do  in  8  core write data
cpu_we  in  1  core write enable
cpu_di  out  8  read data to core, valid the cycle after the accepting edge
cpu_rdy  out  1  core ready, combinational
ram_addr  out  16  RAM address (= cpu_ad)
ram_we  out  1  RAM write strobe
ram_wdata  out  8  RAM write data (= cpu_do)
ram_rdata  in  8  synchronous RAM read data, 1-cycle latency
rom_addr  out  12  ROM address (= cpu_ad[11:0])
rom_rdata  in  8  synchronous ROM read data, 1-cycle latency
io_addr  out  8  registered IO offset
io_wdata  out  8  registered IO write data
io_we  out  1  registered IO write flag
io_req  out  1  IO request, held until acked
io_ack  in  1  IO acknowledge, sampled only while io_req=1
io_rdata  in  8  IO read data, captured on the ack cycle
bus_err  out  1  sticky IO timeout flag

Behaviour:
- Decode priority: cpu_ad[15:8]==IO_PAGE gives IO; else cpu_ad[15:12]==ROM_HI gives ROM; else RAM.
- Accepting edge: any rising clk edge with cpu_rdy=1. At that edge a 2-bit rd_sel register latches the decoded region. cpu_di = mux(rd_sel) of ram_rdata / rom_rdata / io_dreg.
- FSM states: IDLE, WAIT, IO_REQ, IO_DONE. Reset to IDLE.
- IDLE:
  - Region wait count is 0 (RAM_WAIT=0, or ROM with ROM_WAIT=0): cpu_rdy=1; stay in IDLE.
  - ROM/RAM with wait count W>0: cpu_rdy=0; load wcnt=W-1; go to WAIT.
  - IO: cpu_rdy=0; register io_addr=cpu_ad[7:0], io_wdata=cpu_do, io_we=cpu_we; go to IO_REQ.
- WAIT: cpu_rdy=0 while wcnt!=0, decrementing each cycle. When wcnt==0, cpu_rdy=1 and go to IDLE. A W-wait access therefore spends W+1 cycles on one address.
- IO_REQ: io_req=1, cpu_rdy=0. On io_ack=1: io_dreg<=io_rdata on reads (unchanged on writes); io_req drops next cycle; go to IO_DONE.
- IO_DONE: cpu_rdy=1 for exactly one cycle, then IDLE.
- ROM writes: ignored (no strobe); they still take ROM wait states.
- ram_we = cpu_we & cpu_rdy & RAM-decoded. A RAM write therefore commits only on the accepting edge, never during waits.
- io_ack stuck high: each IO access completes in its first IO_REQ cycle. There is exactly one transfer per io_req assertion.
- Reset, asynchronous, may occur mid-operation:
  - state=IDLE, io_req=0, io_we=0, io_addr=0, io_wdata=0, wcnt=0, bus_err=0.
  - rd_sel=IO and io_dreg=8'hFF, so cpu_di=8'hFF until the first accepting edge.
  - cpu_rdy is decode-driven and never X.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - IO_REQ loads a timeout counter to TIMEOUT-1 on entry.
  - If it reaches 0 without io_ack: io_req drops, io_dreg<=8'hFF, bus_err<=1 (sticky until RST), and the FSM goes to IO_DONE.
  - An ack in the same cycle as expiry wins: normal completion, no error.
- Undefined: IO_REQ waits indefinitely; bus_err is tied to 0; no counter is present.

Test Plan:
- Reset release with cpu_ad=16'h0200, cpu_we=0 -> cpu_di=8'hFF before the first edge; cpu_rdy=1; ram_rdata=8'h5A appears on cpu_di the cycle after the accepting edge.
- ROM read at 16'hF123 with ROM_WAIT=2 -> cpu_rdy low for 2 cycles then high for 1; rom_addr=12'h123 throughout; cpu_di=rom_rdata next cycle.
- RAM write 16'h0010 <- 8'hA5 with RAM_WAIT=1 -> ram_we pulses exactly once, on the 2nd cycle (the accepting cycle) only.
- IO read at 16'hFE07 with io_ack after 3 cycles, io_rdata=8'h3C -> io_addr=8'h07, io_req high for 3 cycles, then cpu_rdy one cycle, cpu_di=8'h3C.
- RST asserted while io_req=1 -> io_req=0 immediately (asynchronously); state IDLE; cpu_di=8'hFF.
- With BUS_TIMEOUT_EN, TIMEOUT=4, no ack -> io_req high for 4 cycles; cpu_di=8'hFF; bus_err=1 stays set through subsequent accesses.
